usb_reg_bus_master: RTL

- Initiator side of the CW305 parallel USB register bus (addr / data / rdn / wrn / cen) that the FPGA register front-end responds to.
- Converts a valid/ready command stream (read or write, start address, burst length) into correctly timed bus strobes with programmable setup, strobe and hold phases.
- Captures read bytes and returns them on a result stream.
- Used as an on-chip self-test master and as the bench driver for the register front-end.

---
 rtl/usb_bus_pkg.sv | 25 ++
 rtl/usb_bus_phase_timer.sv | 29 ++
 rtl/usb_reg_bus_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/usb_bus_pkg.sv
// Shared types and constants for the CW305 USB register-bus initiator: FSM
// states, bus idle levels and the phase-timing legality check.
package usb_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  localparam logic STROBE_INACTIVE = 1'b1;
  localparam logic CEN_INACTIVE    = 1'b1;

  // Width of the phase down-counter; bounds the longest programmable phase.
  localparam int TIMER_W = 8;

  function automatic bit timing_ok(input int setup, input int strobe, input int hold);
    return (setup  >= 1) && (setup  <= 2**TIMER_W) &&
           (strobe >= 1) && (strobe <= 2**TIMER_W) &&
           (hold   >= 1) && (hold   <= 2**TIMER_W);
  endfunction

endpackage

// File: rtl/usb_bus_phase_timer.sv
// Phase down-counter: loaded with (phase length - 1) when a phase is entered,
// flags phase_done during the last cycle of that phase.
module usb_bus_phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             phase_done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign phase_done = (count == '0);

endmodule

// File: rtl/usb_reg_bus_master.sv
// Initiator for the CW305 parallel USB register bus: turns read/write burst
// commands into setup/strobe/hold timed bus cycles and returns read bytes.
module usb_reg_bus_master
  import usb_bus_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSETUP        = 2,
  parameter int pSTROBE       = 3,
  parameter int pHOLD         = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [pADDR_WIDTH-1:0]   cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  input  logic [7:0]               wdata,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     busy,
  output logic [pADDR_WIDTH-1:0]   usb_addr,
  output logic [7:0]               usb_dout,
  output logic                     usb_doe,
  input  logic [7:0]               usb_din,
  output logic                     usb_rdn,
  output logic                     usb_wrn,
  output logic                     usb_cen
);

  if (!timing_ok(pSETUP, pSTROBE, pHOLD)) begin : g_bad_timing
    $error("usb_reg_bus_master: pSETUP, pSTROBE and pHOLD must each be in 1..%0d", 2**TIMER_W);
  end

  localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(pSETUP - 1);
  localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(pSTROBE - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(pHOLD - 1);

  state_e                   state, next_state;
  logic                     is_write;
  logic                     cur_write;
  logic [pBYTECNT_SIZE-1:0] beats;
  logic                     cmd_fire, wdata_fire, last_beat;
  logic                     phase_done, timer_load;
  logic [TIMER_W-1:0]       timer_value;
  logic                     read_sample;
  logic                     bus_phase;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign wdata_fire = wdata_valid & wdata_ready;
  assign last_beat  = (beats == '0);
  // The direction of a newly accepted command must steer the outputs
  // registered on the same edge it is latched.
  assign cur_write  = cmd_fire ? cmd_write : is_write;

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (cmd_fire)   next_state = cmd_write ? ST_WDATA : ST_SETUP;
      ST_WDATA:  if (wdata_fire) next_state = ST_SETUP;
      ST_SETUP:  if (phase_done) next_state = ST_STROBE;
      ST_STROBE: if (phase_done) next_state = ST_HOLD;
      ST_HOLD:   if (phase_done) next_state = last_beat ? ST_IDLE
                                            : (is_write ? ST_WDATA : ST_SETUP);
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_value = '0;
    case (next_state)
      ST_SETUP:  timer_value = SETUP_LOAD;
      ST_STROBE: timer_value = STROBE_LOAD;
      ST_HOLD:   timer_value = HOLD_LOAD;
      default:   timer_value = '0;
    endcase
  end

  assign timer_load  = (next_state != state);
  assign read_sample = (state == ST_STROBE) && phase_done && !is_write;
  assign bus_phase   = (next_state == ST_SETUP) || (next_state == ST_STROBE) ||
                       (next_state == ST_HOLD);

  usb_bus_phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (timer_load),
    .load_value (timer_value),
    .phase_done (phase_done)
  );

  // NOTE: only control and bus-visible registers carry a reset; all of them
  // must return to idle levels the moment resetn falls, even mid-strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      beats       <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      wdata_ready <= 1'b0;
      usb_cen     <= CEN_INACTIVE;
      usb_rdn     <= STROBE_INACTIVE;
      usb_wrn     <= STROBE_INACTIVE;
      usb_doe     <= 1'b0;
      usb_addr    <= '0;
      usb_dout    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state       <= next_state;
      cmd_ready   <= (next_state == ST_IDLE);
      busy        <= (next_state != ST_IDLE);
      wdata_ready <= (next_state == ST_WDATA);
      usb_cen     <= (next_state == ST_IDLE) ? CEN_INACTIVE : ~CEN_INACTIVE;
      usb_wrn     <= (next_state == ST_STROBE && cur_write)  ? ~STROBE_INACTIVE : STROBE_INACTIVE;
      usb_rdn     <= (next_state == ST_STROBE && !cur_write) ? ~STROBE_INACTIVE : STROBE_INACTIVE;
      usb_doe     <= cur_write && bus_phase;
      rd_valid    <= read_sample;

      if (read_sample) rd_data  <= usb_din;
      if (wdata_fire)  usb_dout <= wdata;

      if (cmd_fire) begin
        is_write <= cmd_write;
        beats    <= cmd_len;
        usb_addr <= cmd_addr;
      end else if (state == ST_HOLD && phase_done && !last_beat) begin
        beats    <= beats - 1'b1;
        usb_addr <= usb_addr + 1'b1;
      end
    end
  end

endmodule
